incdec_sched: RTL and testbench
===============================

Name: incdec_sched

Overview:
- Round-robin scheduler that shares one IncDec incrementer/decrementer (A±1) among nreq requesters.
- Each requester owns a width-bit counter register. The block holds all counters, arbitrates one inc/dec per cycle, and writes the result back.
- Used wherever several event sources need up/down counters but only one arithmetic unit is affordable.
- A side-band load port configures counter values.

Parameters:
- width, 8: counter word width (>=2)
- nreq, 4: number of requesters/counters (>=2)
- speed, lau_pkg::FAST: speed parameter forwarded to the shared IncDec instance

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- REQ  in  nreq  per-requester operation request; held until granted
- DEC  in  nreq  per-requester op select (1 = decrement, 0 = increment); sampled with REQ
- GNT  out  nreq  one-hot grant; combinational from REQ, LDEN and the priority pointer
- LDEN  in  1  load enable; writes LDVAL into counter LDSEL
- LDSEL  in  $clog2(nreq)  load target index
- LDVAL  in  width  load value
- CNT  out  nreq*width  all counter values, flattened; counter i at [i*width +: width]
- WRAP  out  nreq  one-cycle pulse: counter i wrapped on its last update
- BUSY  out  1  registered; 1 if any REQ bit was high in the previous cycle

Behaviour:
- Reset (RST=1 at a rising edge):
  - all counters = 0, WRAP = 0, BUSY = 0, priority pointer = 0
  - GNT = 0 while RST is high
  - A request pending at reset is dropped; the requester must keep REQ high to be re-granted after reset.
- Handshake:
  - Operation completes in the cycle where REQ[i] & GNT[i].
  - Requester deasserts REQ or presents a new op in the following cycle.
  - DEC[i] must be stable while REQ[i] is high.
- Arbitration:
  - Round-robin from pointer p: grant the first i in p, p+1, …, nreq-1, 0, …, p-1 with REQ[i]=1.
  - At most one GNT bit is set.
  - After a grant to i, p <= (i+1) mod nreq. With no grant, p holds.
- Datapath:
  - Mux selects counter g (the granted index) into the IncDec A input; DEC input = DEC[g].
  - Next edge: counter g <= Z. Latency is 1 cycle; new value visible on CNT the cycle after the grant.
  - Throughput: one operation per cycle.
- Wrap:
  - Increment of all-ones -> 0, or decrement of 0 -> all-ones.
  - WRAP[g] = 1 in the cycle after the grant; all other WRAP bits 0.
  - WRAP is registered and self-clears unless another wrapping op occurs.
- Load:
  - LDEN=1 has priority over arbitration: GNT = 0 that cycle and p holds.
  - Counter LDSEL <= LDVAL at the next edge; no WRAP is generated.
  - LDSEL >= nreq: the load is ignored, but GNT is still suppressed.
- Simultaneous events: LDEN together with REQ to the same index -> load wins and the request stays pending (not granted).
- Counter arithmetic is modulo 2^width; no saturation.
- BUSY <= |REQ every cycle (0 under reset).

Decomposition:
- lau_pkg:
  - provides speed_e (existing)
  - add a sched_idx width helper constant/function for $clog2(nreq)-based index types
  - no new typedefs beyond that
- Sub-module rr_arbiter (parameter nreq):
  - inputs REQ, EN, PTR; outputs one-hot GNT and encoded index
  - purely combinational, with the pointer register kept in incdec_sched
- Shared arithmetic: exactly one IncDec instance (width, speed), instantiated directly.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, then REQ=0 -> CNT all 0, GNT=0, WRAP=0, BUSY=0.
- Round-robin fairness: nreq=4, REQ=4'b1111, DEC=0, held 8 cycles -> GNT sequence 0001,0010,0100,1000,0001,… and every counter = 2.
- Wrap up/down:
  - Load counter 1 = 8'hFF, then REQ[1] inc -> next cycle CNT1 = 8'h00, WRAP = 4'b0010 for one cycle.
  - Then REQ[1] dec -> CNT1 = 8'hFF, WRAP[1] pulses again.
- Load vs request collision: LDEN=1, LDSEL=2, LDVAL=8'h5A with REQ[2]=1 -> GNT=0 that cycle, CNT2 = 8'h5A; next cycle GNT=4'b0100 and CNT2 becomes 8'h5B.
- Pointer skip: p=1, REQ=4'b1001 -> GNT=4'b1000, then p=0 and GNT=4'b0001. Out-of-range LDSEL (nreq=3, LDSEL=3) -> no counter changes, GNT=0.
- Reset mid-operation: REQ[0] granted and RST asserted in the same cycle -> after the edge counter 0 = 0 (no update), p = 0, WRAP = 0.

Source files
------------

// File: rtl/lau_pkg.sv
// lau_pkg: shared types and helpers for the little arithmetic unit library
package lau_pkg;
  typedef enum logic {SLOW, FAST} speed_e;
  function automatic int sched_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/IncDec.sv
// IncDec: Z = A+1 or A-1 (DEC=1); C flags the modulo wrap
module IncDec
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter speed_e speed = FAST
) (
  input  logic [width-1:0] A,
  input  logic             DEC,
  output logic [width-1:0] Z,
  output logic             C
);
  if (speed == FAST) begin : g_fast
    assign Z = DEC ? A - 1'b1 : A + 1'b1;
    assign C = DEC ? ~|A : &A;
  end else begin : g_slow
    // Carry and borrow share one chain: they propagate while A[i] differs from DEC
    logic [width:0] c;
    assign c[0] = 1'b1;
    for (genvar i = 0; i < width; i++) begin : g_bit
      assign Z[i]   = A[i] ^ c[i];
      assign c[i+1] = c[i] & (A[i] ^ DEC);
    end
    assign C = c[width];
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from PTR
module rr_arbiter
  import lau_pkg::*;
#(
  parameter int nreq = 4
) (
  input  logic [nreq-1:0]               REQ,
  input  logic                          EN,
  input  logic [sched_idx_w(nreq)-1:0]  PTR,
  output logic [nreq-1:0]               GNT,
  output logic [sched_idx_w(nreq)-1:0]  IDX
);
  localparam int IW = sched_idx_w(nreq);
  // Lowest requester overall is the wrap-around fallback; lowest at or above PTR overrides it
  always_comb begin
    IDX = '0;
    for (int i = nreq - 1; i >= 0; i--) if (REQ[i]) IDX = IW'(i);
    for (int i = nreq - 1; i >= 0; i--) if (REQ[i] && i >= int'(PTR)) IDX = IW'(i);
    GNT = (EN && |REQ) ? nreq'(1) << IDX : '0;
  end
endmodule

// File: rtl/incdec_sched.sv
// incdec_sched: nreq up/down counters sharing one IncDec through a round-robin arbiter
module incdec_sched
  import lau_pkg::*;
#(
  parameter int     width = 8,
  parameter int     nreq  = 4,
  parameter speed_e speed = FAST
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [nreq-1:0]          REQ,
  input  logic [nreq-1:0]          DEC,
  output logic [nreq-1:0]          GNT,
  input  logic                     LDEN,
  input  logic [$clog2(nreq)-1:0]  LDSEL,
  input  logic [width-1:0]         LDVAL,
  output logic [nreq*width-1:0]    CNT,
  output logic [nreq-1:0]          WRAP,
  output logic                     BUSY
);
  localparam int IW = sched_idx_w(nreq);
  logic [nreq-1:0][width-1:0] cnt_q;
  logic [nreq-1:0]            wrap_q;
  logic                       busy_q;
  logic [IW-1:0]              ptr_q, ptr_d, gidx;
  logic [width-1:0]           z;
  logic                       c, gnt_any, ld_ok;
  // Loads and reset both starve the arbiter so the pointer cannot move
  rr_arbiter #(.nreq(nreq)) u_arb (
    .REQ(REQ),
    .EN (!RST && !LDEN),
    .PTR(ptr_q),
    .GNT(GNT),
    .IDX(gidx)
  );
  IncDec #(.width(width), .speed(speed)) u_incdec (
    .A  (cnt_q[gidx]),
    .DEC(DEC[gidx]),
    .Z  (z),
    .C  (c)
  );
  always_comb begin
    gnt_any = |GNT;
    ld_ok   = LDEN && int'(LDSEL) < nreq;
    ptr_d   = !gnt_any ? ptr_q : (int'(gidx) == nreq - 1) ? '0 : gidx + 1'b1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      wrap_q <= '0;
      busy_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      busy_q <= |REQ;
      wrap_q <= (gnt_any && c) ? GNT : '0;
      ptr_q  <= ptr_d;
      if (ld_ok) cnt_q[LDSEL] <= LDVAL;
      else if (gnt_any) cnt_q[gidx] <= z;
    end
  end
  assign CNT  = cnt_q;
  assign WRAP = wrap_q;
  assign BUSY = busy_q;
endmodule

// File: tb/tb_incdec_sched.sv
// tb_incdec_sched: directed table, corner sequences and randomized model checks
module tb_incdec_sched;
  import lau_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST, LDEN, BUSY;
  logic [3:0]  REQ, DEC, GNT, WRAP;
  logic [1:0]  LDSEL;
  logic [7:0]  LDVAL;
  logic [31:0] CNT;

  incdec_sched #(.width(8), .nreq(4), .speed(FAST)) u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .DEC(DEC), .GNT(GNT), .LDEN(LDEN),
    .LDSEL(LDSEL), .LDVAL(LDVAL), .CNT(CNT), .WRAP(WRAP), .BUSY(BUSY)
  );

  logic        r3_lden, r3_busy;
  logic [2:0]  r3_req, r3_dec, r3_gnt, r3_wrap;
  logic [1:0]  r3_ldsel;
  logic [7:0]  r3_ldval;
  logic [23:0] r3_cnt;

  incdec_sched #(.width(8), .nreq(3), .speed(SLOW)) u_dut3 (
    .CLK(CLK), .RST(RST), .REQ(r3_req), .DEC(r3_dec), .GNT(r3_gnt), .LDEN(r3_lden),
    .LDSEL(r3_ldsel), .LDVAL(r3_ldval), .CNT(r3_cnt), .WRAP(r3_wrap), .BUSY(r3_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: counters as plain integers, pointer as an integer index
  int         m_cnt[4];
  int         m_ptr;
  logic [3:0] m_wrap, m_gnt, got_gnt;
  logic       m_busy;
  logic [2:0] got3;

  function automatic logic [3:0] ref_gnt(input logic rst, input logic [3:0] req, input logic lden, input int ptr);
    if (rst || lden) return 4'b0;
    for (int k = 0; k < 4; k++)
      if (req[2'((ptr + k) % 4)]) return 4'(1) << ((ptr + k) % 4);
    return 4'b0;
  endfunction

  function automatic logic [31:0] m_vec();
    return {8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
  endfunction

  task automatic step(input logic rst, input logic [3:0] req, input logic [3:0] dec,
                      input logic lden, input logic [1:0] ldsel, input logic [7:0] ldval);
    int old;
    RST = rst; REQ = req; DEC = dec; LDEN = lden; LDSEL = ldsel; LDVAL = ldval;
    @(negedge CLK);
    got_gnt = GNT;
    m_gnt = ref_gnt(rst, req, lden, m_ptr);
    @(posedge CLK);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ptr = 0; m_wrap = 0; m_busy = 0;
    end else begin
      m_busy = |req;
      m_wrap = 0;
      if (lden) m_cnt[ldsel] = int'(ldval);
      else for (int i = 0; i < 4; i++) if (m_gnt[2'(i)]) begin
        old = m_cnt[i];
        m_cnt[i] = dec[2'(i)] ? (old + 255) % 256 : (old + 1) % 256;
        m_wrap[2'(i)] = dec[2'(i)] ? (old == 0) : (old == 255);
        m_ptr = (i + 1) % 4;
      end
    end
  endtask

  task automatic step3(input logic [2:0] req, input logic [2:0] dec, input logic lden,
                       input logic [1:0] ldsel, input logic [7:0] ldval);
    r3_req = req; r3_dec = dec; r3_lden = lden; r3_ldsel = ldsel; r3_ldval = ldval;
    @(negedge CLK);
    got3 = r3_gnt;
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req, dec;
    logic        lden;
    logic [1:0]  ldsel;
    logic [7:0]  ldval;
    logic [3:0]  gnt;
    logic [31:0] cnt;
    logic [3:0]  wrap;
    logic        busy;
  } vec_t;
  vec_t tbl[21];

  initial begin
    r3_req = 0; r3_dec = 0; r3_lden = 0; r3_ldsel = 0; r3_ldval = 0;
    //           rst req     dec     ld sel   val    | gnt     cnt           wrap    busy
    tbl[0]  = '{1, 4'h0, 4'h0, 0, 2'd0, 8'h00, 4'h0, 32'h00000000, 4'h0, 0};
    tbl[1]  = '{1, 4'h0, 4'h0, 0, 2'd0, 8'h00, 4'h0, 32'h00000000, 4'h0, 0};
    tbl[2]  = '{0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 4'h0, 32'h00000000, 4'h0, 0};
    tbl[3]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h1, 32'h00000001, 4'h0, 1};
    tbl[4]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h2, 32'h00000101, 4'h0, 1};
    tbl[5]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h4, 32'h00010101, 4'h0, 1};
    tbl[6]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h8, 32'h01010101, 4'h0, 1};
    tbl[7]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h1, 32'h01010102, 4'h0, 1};
    tbl[8]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h2, 32'h01010202, 4'h0, 1};
    tbl[9]  = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h4, 32'h01020202, 4'h0, 1};
    tbl[10] = '{0, 4'hF, 4'h0, 0, 2'd0, 8'h00, 4'h8, 32'h02020202, 4'h0, 1};
    tbl[11] = '{0, 4'h0, 4'h0, 1, 2'd1, 8'hFF, 4'h0, 32'h0202FF02, 4'h0, 0};
    tbl[12] = '{0, 4'h2, 4'h0, 0, 2'd0, 8'h00, 4'h2, 32'h02020002, 4'h2, 1};
    tbl[13] = '{0, 4'h2, 4'h2, 0, 2'd0, 8'h00, 4'h2, 32'h0202FF02, 4'h2, 1};
    tbl[14] = '{0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 4'h0, 32'h0202FF02, 4'h0, 0};
    tbl[15] = '{0, 4'h4, 4'h0, 1, 2'd2, 8'h5A, 4'h0, 32'h025AFF02, 4'h0, 1};
    tbl[16] = '{0, 4'h4, 4'h0, 0, 2'd0, 8'h00, 4'h4, 32'h025BFF02, 4'h0, 1};
    tbl[17] = '{0, 4'h1, 4'h0, 0, 2'd0, 8'h00, 4'h1, 32'h025BFF03, 4'h0, 1};
    tbl[18] = '{0, 4'h9, 4'h0, 0, 2'd0, 8'h00, 4'h8, 32'h035BFF03, 4'h0, 1};
    tbl[19] = '{0, 4'h9, 4'h0, 0, 2'd0, 8'h00, 4'h1, 32'h035BFF04, 4'h0, 1};
    tbl[20] = '{0, 4'h0, 4'h0, 0, 2'd0, 8'h00, 4'h0, 32'h035BFF04, 4'h0, 0};

    for (int r = 0; r < 21; r++) begin
      step(tbl[r].rst, tbl[r].req, tbl[r].dec, tbl[r].lden, tbl[r].ldsel, tbl[r].ldval);
      chk($sformatf("tbl%0d gnt", r), got_gnt, tbl[r].gnt);
      chk($sformatf("tbl%0d cnt", r), CNT, tbl[r].cnt);
      chk($sformatf("tbl%0d wrap", r), WRAP, tbl[r].wrap);
      chk($sformatf("tbl%0d busy", r), BUSY, tbl[r].busy);
    end

    // Reset landing on a pending request with a nonzero pointer
    step(0, 4'h0, 4'h0, 1, 2'd0, 8'h00);
    step(0, 4'h1, 4'h1, 0, 2'd0, 8'h00);
    chk("pre-rst gnt", got_gnt, 4'h1);
    chk("pre-rst cnt", CNT, 32'h035BFFFF);
    chk("pre-rst wrap", WRAP, 4'h1);
    step(1, 4'h1, 4'h1, 0, 2'd0, 8'h00);
    chk("rst-op gnt", got_gnt, 4'h0);
    chk("rst-op cnt", CNT, 32'h0);
    chk("rst-op wrap", WRAP, 4'h0);
    chk("rst-op busy", BUSY, 1'b0);
    step(0, 4'h3, 4'h0, 0, 2'd0, 8'h00);
    chk("post-rst ptr gnt", got_gnt, 4'h1);
    chk("post-rst cnt", CNT, 32'h00000001);

    for (int n = 0; n < 400; n++) begin
      step($urandom_range(49) == 0, 4'($urandom), 4'($urandom), $urandom_range(7) == 0,
           2'($urandom), 8'($urandom));
      chk($sformatf("rnd%0d gnt", n), got_gnt, m_gnt);
      chk($sformatf("rnd%0d cnt", n), CNT, m_vec());
      chk($sformatf("rnd%0d wrap", n), WRAP, m_wrap);
      chk($sformatf("rnd%0d busy", n), BUSY, m_busy);
    end

    // Three-requester instance: out-of-range load and slow-path wrap
    RST = 0; REQ = 0; LDEN = 0;
    step3(3'b000, 3'b000, 1, 2'd0, 8'h11);
    step3(3'b000, 3'b000, 1, 2'd1, 8'h00);
    step3(3'b000, 3'b000, 1, 2'd2, 8'h33);
    chk("n3 load cnt", r3_cnt, 24'h330011);
    step3(3'b111, 3'b000, 1, 2'd3, 8'hEE);
    chk("n3 oob gnt", got3, 3'b000);
    chk("n3 oob cnt", r3_cnt, 24'h330011);
    step3(3'b010, 3'b010, 0, 2'd0, 8'h00);
    chk("n3 dec gnt", got3, 3'b010);
    chk("n3 dec cnt", r3_cnt, 24'h33FF11);
    chk("n3 dec wrap", r3_wrap, 3'b010);
    step3(3'b111, 3'b000, 0, 2'd0, 8'h00);
    chk("n3 rr gnt", got3, 3'b100);
    chk("n3 rr cnt", r3_cnt, 24'h34FF11);
    chk("n3 rr wrap", r3_wrap, 3'b000);
    step3(3'b011, 3'b000, 0, 2'd0, 8'h00);
    chk("n3 wrapptr gnt", got3, 3'b001);
    chk("n3 wrapptr cnt", r3_cnt, 24'h34FF12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
